// File: rtl/ber_checker.sv
// BER checker: decimates and slices the pulse-shaping filter output, searches the
// PRBS symbol delay, then accumulates bit and error counts while locked.
module ber_checker #(
  parameter int NB_INPUT  = 13,
  parameter int OVER_SAMP = 8,
  parameter int NB_COUNT  = 3,
  parameter int DELAY_MAX = 32,
  parameter int NB_DELAY  = 5,
  parameter int WINDOW    = 511,
  parameter int NB_WIN    = 9,
  parameter int LOSS_THR  = 8,
  parameter int NB_CNT    = 64
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic                       i_enable,
  input  logic                       i_valid,
  input  logic                       i_prbs,
  input  logic signed [NB_INPUT-1:0] i_data,
  input  logic        [NB_COUNT-1:0] i_phase,
  input  logic                       i_clear,
  output logic                       o_sym,
  output logic                       o_sym_valid,
  output logic                       o_locked,
  output logic        [NB_DELAY-1:0] o_delay,
  output logic        [NB_CNT-1:0]   o_bit_count,
  output logic        [NB_CNT-1:0]   o_err_count
);

  typedef enum logic {ST_SEARCH = 1'b0, ST_LOCKED = 1'b1} state_t;

  localparam logic [NB_COUNT-1:0] PHASE_LAST = NB_COUNT'(OVER_SAMP - 1);
  localparam logic [NB_DELAY-1:0] DELAY_LAST = NB_DELAY'(DELAY_MAX - 1);
  localparam logic [NB_WIN-1:0]   WIN_LAST   = NB_WIN'(WINDOW - 1);
  localparam logic [NB_WIN:0]     LOSS_LIM   = (NB_WIN + 1)'(LOSS_THR);

  state_t               state_q, state_d;
  logic [NB_COUNT-1:0]  phase_q, phase_d;
  logic [DELAY_MAX-1:0] ref_q, ref_d;
  logic                 sym_q, sym_d;
  logic                 sym_valid_q, sym_valid_d;
  logic [NB_DELAY-1:0]  delay_q, delay_d;
  logic [NB_WIN-1:0]    win_cnt_q, win_cnt_d;
  logic [NB_WIN-1:0]    win_err_q, win_err_d;
  logic [NB_CNT-1:0]    bit_cnt_q, bit_cnt_d;
  logic [NB_CNT-1:0]    err_cnt_q, err_cnt_d;

  logic                 strobe;
  logic                 sliced;
  logic                 mismatch;
  logic                 win_end;
  logic [NB_WIN:0]      win_total;

  assign strobe    = i_enable && (phase_q == i_phase);
  assign sliced    = i_data[NB_INPUT-1];
  // ref_q is read before this cycle's shift, so a coincident i_valid is not seen yet
  assign mismatch  = sliced ^ ref_q[delay_q];
  assign win_end   = strobe && (win_cnt_q == WIN_LAST);
  assign win_total = {1'b0, win_err_q} + {{NB_WIN{1'b0}}, mismatch};

  always_comb begin
    phase_d     = phase_q;
    ref_d       = ref_q;
    sym_d       = sym_q;
    sym_valid_d = 1'b0;
    if (i_enable) begin
      phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
      if (i_valid) begin
        ref_d = {ref_q[DELAY_MAX-2:0], i_prbs};
      end
    end
    if (strobe && !i_clear) begin
      sym_d       = sliced;
      sym_valid_d = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    bit_cnt_d = bit_cnt_q;
    err_cnt_d = err_cnt_q;
    if (i_clear) begin
      state_d   = ST_SEARCH;
      delay_d   = '0;
      win_cnt_d = '0;
      win_err_d = '0;
      bit_cnt_d = '0;
      err_cnt_d = '0;
    end else if (strobe) begin
      if (win_end) begin
        win_cnt_d = '0;
        win_err_d = '0;
      end else begin
        win_cnt_d = win_cnt_q + 1'b1;
        if (win_err_q != '1) begin
          win_err_d = win_err_q + {{(NB_WIN-1){1'b0}}, mismatch};
        end
      end
      case (state_q)
        ST_SEARCH: begin
          if (win_end) begin
            if (win_total == '0) begin
              state_d = ST_LOCKED;
            end else begin
              delay_d = (delay_q == DELAY_LAST) ? '0 : delay_q + 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (bit_cnt_q != '1) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
          if (mismatch && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
          // counters are kept on loss of lock so the measurement survives a re-search
          if (win_end && (win_total > LOSS_LIM)) begin
            state_d = ST_SEARCH;
            delay_d = '0;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_SEARCH;
      phase_q     <= '0;
      ref_q       <= '0;
      sym_q       <= 1'b0;
      sym_valid_q <= 1'b0;
      delay_q     <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      ref_q       <= ref_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
      delay_q     <= delay_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      bit_cnt_q   <= bit_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_sym       = sym_q;
  assign o_sym_valid = sym_valid_q;
  assign o_locked    = (state_q == ST_LOCKED);
  assign o_delay     = delay_q;
  assign o_bit_count = bit_cnt_q;
  assign o_err_count = err_cnt_q;

endmodule
